// File: rtl/scirc529_obs.sv
// scirc529_obs: observer/decoder for the four-state sequence generator.
// Watches the generator's 2-bit state stream, recovers the input bit that
// caused each transition, flags illegal transitions, and packs recovered
// bits LSB-first into WORD_W-bit words offered on a valid/ready port.

module scirc529_obs #(
    parameter int WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        y_in_i2,
    input  logic              y_vld_i,
    input  logic              clr_i,
    output logic              x_out_o,
    output logic              x_vld_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_vld_o,
    input  logic              word_rdy_i,
    output logic              err_o,
    output logic              ovf_o
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    // TRACK decodes every sample against the previous one; HUNT only
    // re-acquires a reference state after a clear.
    typedef enum logic {
        TRACK = 1'b0,
        HUNT  = 1'b1
    } mode_e;

    // Decode one transition: returns {legal, x}.
    function automatic logic [1:0] decode_f(input logic [1:0] prev,
                                            input logic [1:0] samp);
        logic [1:0] res;
        res = 2'b00;
        case (prev)
            2'b00: begin
                case (samp)
                    2'b00:   res = 2'b10;
                    2'b01:   res = 2'b11;
                    default: res = 2'b00;
                endcase
            end
            2'b01: begin
                case (samp)
                    2'b11:   res = 2'b10;
                    2'b10:   res = 2'b11;
                    default: res = 2'b00;
                endcase
            end
            2'b10: begin
                case (samp)
                    2'b11:   res = 2'b10;
                    2'b10:   res = 2'b11;
                    default: res = 2'b00;
                endcase
            end
            2'b11: begin
                case (samp)
                    2'b00:   res = 2'b10;
                    2'b11:   res = 2'b11;
                    default: res = 2'b00;
                endcase
            end
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    // State flops
    mode_e              mode_q,     mode_d;
    logic [1:0]         prev_q,     prev_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WORD_W-1:0]  shift_q,    shift_d;
    logic               x_out_q,    x_out_d;
    logic               x_vld_q,    x_vld_d;
    logic [WORD_W-1:0]  word_q,     word_d;
    logic               word_vld_q, word_vld_d;
    logic               err_q,      err_d;
    logic               ovf_q,      ovf_d;

    // Combinational helpers
    logic [1:0]         dec_s;
    logic               legal_s;
    logic               x_s;
    logic [WORD_W-1:0]  packed_s;
    logic               xfer_s;

    // Decode the current sample and form the shift register with the new bit placed.
    always_comb begin
        dec_s    = decode_f(prev_q, y_in_i2);
        legal_s  = dec_s[1];
        x_s      = dec_s[0];
        packed_s = shift_q;
        packed_s[cnt_q] = x_s;
        xfer_s   = word_vld_q & word_rdy_i;
    end

    // Next-state logic for mode, sample tracking, packing and the output word.
    always_comb begin
        mode_d     = mode_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        x_out_d    = x_out_q;
        x_vld_d    = 1'b0;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        // A consumer transfer retires the current word unless a new one lands below.
        if (xfer_s) begin
            word_vld_d = 1'b0;
        end else begin
            word_vld_d = word_vld_q;
        end

        if (clr_i) begin
            // Clear beats any same-cycle sample; the word port keeps running.
            err_d  = 1'b0;
            ovf_d  = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
            mode_d = HUNT;
        end else if (y_vld_i) begin
            case (mode_q)
                HUNT: begin
                    // Re-acquire the reference without emitting a bit.
                    prev_d = y_in_i2;
                    mode_d = TRACK;
                end
                TRACK: begin
                    prev_d = y_in_i2;
                    if (legal_s) begin
                        x_out_d = x_s;
                        x_vld_d = 1'b1;
                        shift_d = packed_s;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d = {CNT_W{1'b0}};
                            if (!word_vld_q || word_rdy_i) begin
                                word_d     = packed_s;
                                word_vld_d = 1'b1;
                            end else begin
                                // Previous word still pending: drop this one.
                                ovf_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // Illegal transition: flag it, discard the partial
                        // word, and take this sample as the new reference.
                        err_d = 1'b1;
                        cnt_d = {CNT_W{1'b0}};
                    end
                end
                default: begin
                    mode_d = TRACK;
                end
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // All state registers; asynchronous reset re-arms tracking from S0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_q     <= TRACK;
            prev_q     <= 2'b00;
            cnt_q      <= {CNT_W{1'b0}};
            shift_q    <= {WORD_W{1'b0}};
            x_out_q    <= 1'b0;
            x_vld_q    <= 1'b0;
            word_q     <= {WORD_W{1'b0}};
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            x_out_q    <= x_out_d;
            x_vld_q    <= x_vld_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign x_out_o    = x_out_q;
    assign x_vld_o    = x_vld_q;
    assign word_o     = word_q;
    assign word_vld_o = word_vld_q;
    assign err_o      = err_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_scirc529_obs.sv
// Bench for scirc529_obs: directed vector table, hand-written corner
// sequences, then randomized traffic against a transition-table model.

module tb_scirc529_obs;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic [1:0]   y_in = 2'b00;
    logic         y_vld = 1'b0;
    logic         clr = 1'b0;
    logic         rdy = 1'b0;
    logic         x_out, x_vld, word_vld, err, ovf;
    logic [W-1:0] word;

    int checks = 0;
    int failures = 0;

    scirc529_obs #(.WORD_W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .y_in_i2    (y_in),
        .y_vld_i    (y_vld),
        .clr_i      (clr),
        .x_out_o    (x_out),
        .x_vld_o    (x_vld),
        .word_o     (word),
        .word_vld_o (word_vld),
        .word_rdy_i (rdy),
        .err_o      (err),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (generator view) ----------------
    // Next generator state for x=0 / x=1 from each state.
    int nxt0 [4] = '{0, 3, 3, 0};
    int nxt1 [4] = '{1, 2, 2, 3};

    int         m_prev;
    bit         m_hunt;
    bit         m_bits[$];
    bit         m_x, m_xv, m_wv, m_err, m_ovf;
    bit [W-1:0] m_word;

    function automatic void model_reset();
        m_prev = 0; m_hunt = 0; m_bits.delete();
        m_x = 0; m_xv = 0; m_wv = 0; m_err = 0; m_ovf = 0; m_word = '0;
    endfunction

    function automatic void model_step(bit c, bit v, int y, bit r);
        bit nwv;
        bit [W-1:0] w;
        nwv  = m_wv && !(m_wv && r);
        m_xv = 0;
        if (c) begin
            m_err = 0; m_ovf = 0; m_bits.delete(); m_hunt = 1;
        end else if (v) begin
            if (m_hunt) begin
                m_hunt = 0;
            end else if (y == nxt0[m_prev] || y == nxt1[m_prev]) begin
                m_x  = (y == nxt1[m_prev]);
                m_xv = 1;
                m_bits.push_back(m_x);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = m_bits[i];
                    if (!m_wv || r) begin
                        m_word = w; nwv = 1;
                    end else begin
                        m_ovf = 1;
                    end
                    m_bits.delete();
                end
            end else begin
                m_err = 1; m_bits.delete();
            end
            m_prev = y;
        end
        m_wv = nwv;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit ex, input bit exv, input logic [W-1:0] ew,
                           input bit ewv, input bit ee, input bit eo);
        chk({tag, ".x_out"},    32'(x_out),    32'(ex));
        chk({tag, ".x_vld"},    32'(x_vld),    32'(exv));
        chk({tag, ".word"},     32'(word),     32'(ew));
        chk({tag, ".word_vld"}, 32'(word_vld), 32'(ewv));
        chk({tag, ".err"},      32'(err),      32'(ee));
        chk({tag, ".ovf"},      32'(ovf),      32'(eo));
    endtask

    task automatic step(input bit c, input bit v, input logic [1:0] y, input bit r);
        clr = c; y_vld = v; y_in = y; rdy = r;
        model_step(c, v, int'(y), r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 0; y_vld = 0; y_in = 2'b00; rdy = 0;
        rst_i = 1'b0;
        #1;
        chk_all("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b1;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit c; bit v; logic [1:0] y; bit r;
        bit ex; bit exv; logic [7:0] ew; bit ewv; bit ee; bit eo;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Clean decode of the worked example, word 8'h47.
        vecs[0]  = '{1'b0,1'b1,2'b01,1'b0, 1'b1,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,2'b10,1'b0, 1'b1,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,2'b10,1'b0, 1'b1,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,2'b11,1'b0, 1'b0,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,2'b00,1'b0, 1'b0,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,2'b00,1'b0, 1'b0,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,2'b01,1'b0, 1'b1,1'b1,8'h00,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,2'b11,1'b0, 1'b0,1'b1,8'h47,1'b1,1'b0,1'b0};
        // Consumer takes the word.
        vecs[8]  = '{1'b0,1'b0,2'b00,1'b1, 1'b0,1'b0,8'h47,1'b0,1'b0,1'b0};
        // S3->S1 illegal, then S1->S3 legal x=0.
        vecs[9]  = '{1'b0,1'b1,2'b01,1'b0, 1'b0,1'b0,8'h47,1'b0,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b1,2'b11,1'b0, 1'b0,1'b1,8'h47,1'b0,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,2'b00,1'b0, 1'b0,1'b1,8'h47,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,2'b01,1'b0, 1'b1,1'b1,8'h47,1'b0,1'b1,1'b0};
        // Clear with a same-cycle sample that must be ignored.
        vecs[13] = '{1'b1,1'b1,2'b10,1'b0, 1'b1,1'b0,8'h47,1'b0,1'b0,1'b0};
        // HUNT sample, then S3->S0 gives x=0.
        vecs[14] = '{1'b0,1'b1,2'b11,1'b0, 1'b1,1'b0,8'h47,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b1,2'b00,1'b0, 1'b0,1'b1,8'h47,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b0,2'b00,1'b0, 1'b0,1'b0,8'h47,1'b0,1'b0,1'b0};
    end

    // Test sequence.
    initial begin
        logic [1:0] seq_b [8];
        int ry;
        bit rc, rv, rr;

        rst_i = 1'b1;
        #2;
        do_reset();

        // ---- table ----
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].c, vecs[i].v, vecs[i].y, vecs[i].r);
            chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].exv, vecs[i].ew,
                    vecs[i].ewv, vecs[i].ee, vecs[i].eo);
        end

        // ---- overflow, then clear with both flags set ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 2'b00, 1'b0);
            if (i == 7)  chk_all("ovf.first", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i == 15) chk_all("ovf.drop",  1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b1, 2'b11, 1'b0);   // S0->S3 illegal
        chk_all("ovf.err", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 2'b00, 1'b0);   // x=0
        step(1'b0, 1'b1, 2'b01, 1'b0);   // x=1
        step(1'b0, 1'b1, 2'b11, 1'b0);   // x=0
        chk_all("clr.pre", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        chk_all("clr.flags", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        chk_all("clr.hunt", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk_all("clr.resume", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

        // ---- new word lands on the same edge as a transfer ----
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'b00, 1'b0);
        chk_all("ovl.first", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        seq_b = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, seq_b[i], 1'b0);
        chk_all("ovl.hold", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, seq_b[7], 1'b1);
        chk_all("ovl.swap", 1'b0, 1'b1, 8'h49, 1'b1, 1'b0, 1'b0);

        // ---- gaps, then async reset mid-word ----
        do_reset();
        step(1'b0, 1'b1, 2'b01, 1'b0);
        chk_all("gap.s1", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'(i), 1'b0);
            chk_all($sformatf("gap.idle%0d", i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 2'b11, 1'b0);   // S1->S3 x=0
        chk_all("gap.resume", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b11, 1'b0);   // S3->S3 x=1
        chk_all("gap.s3s3", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 2'b01, 1'b0);   // S0->S1 after re-arm
        chk_all("rearm", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            rc = ($urandom_range(0, 99) < 3);
            rv = ($urandom_range(0, 99) < 75);
            rr = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 85)
                ry = ($urandom_range(0, 1) == 1) ? nxt1[m_prev] : nxt0[m_prev];
            else
                ry = int'($urandom_range(0, 3));
            step(rc, rv, 2'(ry), rr);
            chk_all($sformatf("rnd%0d", n), m_x, m_xv, m_word, m_wv, m_err, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
